// File: rtl/audio_playback_sequencer.sv
// audio_playback_sequencer
//   Top-level sequencer for the audio player serial datapath. A start request runs
//   a short prepacket phase. The block then streams PKT_LAST+1 packets of 32 bits
//   each, and repeats the whole message REPEATS times. It drives the serializer
//   load strobe and the packet/bit/repeat counters that feed the output driver.
//
//   Optional feature: define LOOP_FOREVER_EN to repeat the message indefinitely.
//   In that mode rep_count wraps to 0, done never pulses, and playback ends only
//   on stop or reset.
//
// Ports
//   clk               in   system clock
//   reset             in   asynchronous reset, active-high
//   start             in   begins playback when idle (level or pulse)
//   stop              in   synchronous abort; highest priority, returns to idle
//   bit_tick          in   1-cycle enable, one per serial bit period
//   prepacket         out  high during the prepacket phase
//   packets           out  current packet index 0..PKT_LAST
//   thirty_two_count  out  bit index within the packet 0..31
//   rep_count         out  completed message repetitions
//   load_word         out  1-cycle strobe: serializer loads the next 32-bit word
//   busy              out  high while in prepacket or streaming
//   done              out  1-cycle pulse when all repetitions have finished
module audio_playback_sequencer #(
  parameter int PRE_TICKS = 16,
  parameter int PKT_LAST  = 936,
  parameter int REPEATS   = 400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       bit_tick,
  output logic       prepacket,
  output logic [9:0] packets,
  output logic [4:0] thirty_two_count,
  output logic [8:0] rep_count,
  output logic       load_word,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_STREAM, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] pre_cnt;
  logic       pre_last, bit_last, pkt_last, rep_last, msg_end;

  assign pre_last = bit_tick && (pre_cnt == 8'(PRE_TICKS - 1));
  assign bit_last = (thirty_two_count == 5'd31);
  assign pkt_last = (packets == 10'(PKT_LAST));
  assign rep_last = (rep_count == 9'(REPEATS - 1));

  // Final bit of the final packet of the final repetition. In loop mode this
  // point does not exist; the last repetition simply wraps to the first.
`ifdef LOOP_FOREVER_EN
  assign msg_end = 1'b0;
`else
  assign msg_end = bit_tick && bit_last && pkt_last && rep_last;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; stop overrides everything
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start)    state_d = S_PRE;
        S_PRE:    if (pre_last) state_d = S_STREAM;
        S_STREAM: if (msg_end)  state_d = S_DONE;
        S_DONE:                 state_d = S_IDLE;
        default:                state_d = S_IDLE;
      endcase
    end
  end

  // Outputs. load_word is combinational with bit_tick, so the serializer loads
  // on the same edge that the counters roll over.
  always_comb begin
    prepacket = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    load_word = 1'b0;
    case (state_q)
      S_PRE: begin
        prepacket = 1'b1;
        busy      = 1'b1;
        load_word = pre_last && !stop;
      end
      S_STREAM: begin
        busy      = 1'b1;
        load_word = bit_tick && bit_last && !msg_end && !stop;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Counters. They are cleared while idle and on the edge that leaves DONE, so
  // DONE still shows the final values for its single cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt          <= '0;
      thirty_two_count <= '0;
      packets          <= '0;
      rep_count        <= '0;
    end else if (stop || state_q == S_IDLE || state_q == S_DONE) begin
      pre_cnt          <= '0;
      thirty_two_count <= '0;
      packets          <= '0;
      rep_count        <= '0;
    end else if (state_q == S_PRE) begin
      if (bit_tick) pre_cnt <= pre_cnt + 8'd1;
    end else if (bit_tick) begin
      if (!bit_last) begin
        thirty_two_count <= thirty_two_count + 5'd1;
      end else if (!pkt_last) begin
        thirty_two_count <= '0;
        packets          <= packets + 10'd1;
      end else if (!rep_last) begin
        thirty_two_count <= '0;
        packets          <= '0;
        rep_count        <= rep_count + 9'd1;
      end else begin
`ifdef LOOP_FOREVER_EN
        thirty_two_count <= '0;
        packets          <= '0;
        rep_count        <= '0;
`else
        // Bit and packet counters hold at their last values through DONE.
        rep_count        <= 9'(REPEATS);
`endif
      end
    end
  end

endmodule

// File: tb/tb_audio_playback_sequencer.sv
module tb_audio_playback_sequencer;
  localparam int PRE      = 2;
  localparam int PKT_LAST = 3;
  localparam int REPEATS  = 2;
  localparam int P        = PKT_LAST + 1;
  localparam int W        = 32 * P;
  localparam int TOT      = REPEATS * W;

  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, bit_tick = 1'b0;
  logic       prepacket, load_word, busy, done;
  logic [9:0] packets;
  logic [4:0] thirty_two_count;
  logic [8:0] rep_count;

  int total = 0, bad = 0;
  // reference model: phase 0 idle, 1 active (mn ticks since start), 2 done
  int mphase = 0, mn = 0;
  int done_cnt = 0, done_at = -1, ticks_seen = 0, phase = 0;

  typedef struct {
    bit s, p, t;
    bit busy, pp, load;
  } vec_t;
  vec_t vecs[8];

  audio_playback_sequencer #(.PRE_TICKS(PRE), .PKT_LAST(PKT_LAST), .REPEATS(REPEATS)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .bit_tick(bit_tick),
    .prepacket(prepacket), .packets(packets), .thirty_two_count(thirty_two_count),
    .rep_count(rep_count), .load_word(load_word), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs from the playback rules: position in the message is plain
  // arithmetic on the number of ticks seen since playback started.
  task automatic check_model();
    int e_pp, e_busy, e_done, e_load, e_pkt, e_bit, e_rep, m;
    e_pp = 0; e_busy = 0; e_done = 0; e_load = 0; e_pkt = 0; e_bit = 0; e_rep = 0;
    if (mphase == 1) begin
      e_busy = 1;
      if (mn < PRE) begin
        e_pp   = 1;
        e_load = int'(bit_tick && !stop && (mn == PRE - 1));
      end else begin
        m      = mn - PRE;
        e_bit  = m % 32;
        e_pkt  = (m / 32) % P;
        e_rep  = (m / W) % REPEATS;
        e_load = int'(bit_tick && !stop && (m % 32 == 31));
`ifndef LOOP_FOREVER_EN
        if (m == TOT - 1) e_load = 0;
`endif
      end
    end else if (mphase == 2) begin
      e_done = 1; e_bit = 31; e_pkt = PKT_LAST; e_rep = REPEATS;
    end
    chk("prepacket", int'(prepacket), e_pp);
    chk("busy", int'(busy), e_busy);
    chk("done", int'(done), e_done);
    chk("load_word", int'(load_word), e_load);
    chk("packets", int'(packets), e_pkt);
    chk("bit_count", int'(thirty_two_count), e_bit);
    chk("rep_count", int'(rep_count), e_rep);
  endtask

  task automatic model_update(input bit s, input bit p, input bit t);
    if (p) mphase = 0;
    else case (mphase)
      0: if (s) begin mphase = 1; mn = 0; end
      1: if (t) begin
           mn++;
`ifndef LOOP_FOREVER_EN
           if (mn == PRE + TOT) mphase = 2;
`endif
         end
      default: mphase = 0;
    endcase
    if (t) ticks_seen++;
  endtask

  task automatic cycle(input bit s, input bit p, input bit t);
    start = s; stop = p; bit_tick = t;
    #2;
    check_model();
    if (done) begin done_cnt++; done_at = ticks_seen; end
    @(posedge clk);
    model_update(s, p, t);
    #1;
  endtask

  // bit_tick once every 4 clocks
  task automatic tcycle(input bit s, input bit p);
    cycle(s, p, (phase % 4) == 0);
    phase++;
  endtask

  initial begin
    bit hit;
    // start+stop together, then start, PRE with load on 2nd tick, stop in STREAM
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // reset state
    #2;
    check_model();
    #10 reset = 1'b0;
    @(posedge clk); #1;

    // table vectors
    for (int i = 0; i < 8; i++) begin
      start = vecs[i].s; stop = vecs[i].p; bit_tick = vecs[i].t;
      #2;
      chk($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].busy));
      chk($sformatf("vec%0d prepacket", i), int'(prepacket), int'(vecs[i].pp));
      chk($sformatf("vec%0d load_word", i), int'(load_word), int'(vecs[i].load));
      cycle(vecs[i].s, vecs[i].p, vecs[i].t);
    end

`ifndef LOOP_FOREVER_EN
    // full playback: one done after PRE + REPEATS*(PKT_LAST+1)*32 ticks
    done_cnt = 0; ticks_seen = 0; phase = 1;
    tcycle(1'b1, 1'b0);
    for (int k = 0; k < 1500 && done_cnt == 0; k++) tcycle(1'b0, 1'b0);
    chk("t1 done count", done_cnt, 1);
    chk("t1 done tick", done_at, PRE + TOT);
    tcycle(1'b0, 1'b0);
    chk("t1 idle busy", int'(busy), 0);
    chk("t1 idle rep", int'(rep_count), 0);
`else
    // loop forever: rep_count wraps, streaming continues, never done
    done_cnt = 0; ticks_seen = 0; phase = 1;
    tcycle(1'b1, 1'b0);
    for (int k = 0; k < 1400; k++) tcycle(1'b0, 1'b0);
    chk("t6 done count", done_cnt, 0);
    chk("t6 still busy", int'(busy), 1);
    tcycle(1'b0, 1'b1);
`endif

    // stop at packets=2, bit=17, rep=1
    done_cnt = 0; phase = 1; hit = 1'b0;
    tcycle(1'b1, 1'b0);
    for (int k = 0; k < 2000 && !hit; k++) begin
      if (packets == 10'd2 && thirty_two_count == 5'd17 && rep_count == 9'd1) hit = 1'b1;
      else tcycle(1'b0, 1'b0);
    end
    chk("t2 reached stop point", int'(hit), 1);
    cycle(1'b0, 1'b1, 1'b1);
    chk("t2 busy", int'(busy), 0);
    chk("t2 packets", int'(packets), 0);
    chk("t2 bit_count", int'(thirty_two_count), 0);
    chk("t2 rep_count", int'(rep_count), 0);
    for (int k = 0; k < 20; k++) tcycle(1'b0, 1'b0);
    chk("t2 no done", done_cnt, 0);

`ifndef LOOP_FOREVER_EN
    // start hammered during playback is ignored
    done_cnt = 0; ticks_seen = 0; phase = 1;
    tcycle(1'b1, 1'b0);
    for (int k = 0; k < 1500 && done_cnt == 0; k++) tcycle(1'($urandom_range(0, 1)), 1'b0);
    chk("t3 done count", done_cnt, 1);
    chk("t3 done tick", done_at, PRE + TOT);
    for (int k = 0; k < 4; k++) tcycle(1'b0, 1'b0);
`endif

    // async reset mid-PRE, between edges
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("t4 in pre", int'(prepacket), 1);
    #2 reset = 1'b1;
    #1;
    chk("t4 async busy", int'(busy), 0);
    chk("t4 async prepacket", int'(prepacket), 0);
    mphase = 0;
    @(posedge clk);
    #3 reset = 1'b0;
    for (int k = 0; k < 12; k++) tcycle(1'b0, 1'b0);
    chk("t4 stays idle", int'(busy), 0);
    tcycle(1'b1, 1'b0);
    tcycle(1'b0, 1'b0);
    chk("t4 restart busy", int'(busy), 1);
    tcycle(1'b0, 1'b1);

    // random stimulus against the model
    for (int k = 0; k < 3000; k++)
      cycle(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 299) == 0),
            1'($urandom_range(0, 2) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
